// File: rtl/tx_trn_arbiter_pkg.sv
// Shared definitions for the TRN TX arbiter: FSM state encodings and the
// values the TX bus shows while no requester holds it.
package tx_trn_arbiter_pkg;

    // One-hot FSM encoding
    typedef enum logic [3:0] {
        ST_IDLE  = 4'b0001,
        ST_OFFER = 4'b0010,
        ST_GUARD = 4'b0100,
        ST_BUSY  = 4'b1000
    } arb_state_t;

    localparam int TRN_TD_W  = 64;
    localparam int TRN_REM_W = 8;

    // Idle bus values presented to the endpoint
    localparam logic [TRN_TD_W-1:0]  TRN_TD_IDLE   = '0;
    localparam logic [TRN_REM_W-1:0] TRN_TREM_IDLE = 8'hFF;
    localparam logic                 TRN_CTL_IDLE  = 1'b1;

endpackage

// File: rtl/tx_trn_arbiter_mux.sv
// Purely combinational TRN TX bus selector: picks slice sel from the
// per-requester buses, or presents idle values when not active.
module tx_trn_mux
    import tx_trn_arbiter_pkg::*;
#(
    parameter int N_REQ = 3,
    parameter int PTR_W = 2
) (
    input  logic [PTR_W-1:0]           sel,
    input  logic                       active,
    input  logic [N_REQ*TRN_TD_W-1:0]  req_trn_td,
    input  logic [N_REQ*TRN_REM_W-1:0] req_trn_trem_n,
    input  logic [N_REQ-1:0]           req_trn_tsof_n,
    input  logic [N_REQ-1:0]           req_trn_teof_n,
    input  logic [N_REQ-1:0]           req_trn_tsrc_rdy_n,
    output logic [TRN_TD_W-1:0]        trn_td,
    output logic [TRN_REM_W-1:0]       trn_trem_n,
    output logic                       trn_tsof_n,
    output logic                       trn_teof_n,
    output logic                       trn_tsrc_rdy_n
);

    logic [TRN_TD_W-1:0]  td_arr   [N_REQ];
    logic [TRN_REM_W-1:0] trem_arr [N_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_slice
            assign td_arr[gi]   = req_trn_td[gi*TRN_TD_W +: TRN_TD_W];
            assign trem_arr[gi] = req_trn_trem_n[gi*TRN_REM_W +: TRN_REM_W];
        end
    endgenerate

    // Select the owning slice, or force idle values; no registers on this path
    always_comb begin
        trn_td         = TRN_TD_IDLE;
        trn_trem_n     = TRN_TREM_IDLE;
        trn_tsof_n     = TRN_CTL_IDLE;
        trn_teof_n     = TRN_CTL_IDLE;
        trn_tsrc_rdy_n = TRN_CTL_IDLE;
        if (active) begin
            trn_td         = td_arr[sel];
            trn_trem_n     = trem_arr[sel];
            trn_tsof_n     = req_trn_tsof_n[sel];
            trn_teof_n     = req_trn_teof_n[sel];
            trn_tsrc_rdy_n = req_trn_tsrc_rdy_n[sel];
        end
    end

endmodule

// File: rtl/tx_trn_arbiter.sv
// Round-robin arbiter sharing one TRN TX interface among N_REQ requesters.
// Each requester in turn is offered the bus for GRANT_WIN cycles plus one
// guard cycle; once it drives, it owns the bus until it drops its flag.
// Optional feature macro: TX_ARB_WATCHDOG_EN (busy-cycle watchdog that
// forcibly reclaims the bus after WD_LIMIT BUSY cycles).
module tx_trn_arbiter
    import tx_trn_arbiter_pkg::*;
#(
    parameter int N_REQ     = 3,
    parameter int GRANT_WIN = 4,
    parameter int WD_LIMIT  = 1024
) (
    input  logic                       trn_clk,
    input  logic                       reset_n,
    output logic [N_REQ-1:0]           my_turn,
    input  logic [N_REQ-1:0]           driving_interface,
    input  logic [N_REQ*TRN_TD_W-1:0]  req_trn_td,
    input  logic [N_REQ*TRN_REM_W-1:0] req_trn_trem_n,
    input  logic [N_REQ-1:0]           req_trn_tsof_n,
    input  logic [N_REQ-1:0]           req_trn_teof_n,
    input  logic [N_REQ-1:0]           req_trn_tsrc_rdy_n,
    output logic [TRN_TD_W-1:0]        trn_td,
    output logic [TRN_REM_W-1:0]       trn_trem_n,
    output logic                       trn_tsof_n,
    output logic                       trn_teof_n,
    output logic                       trn_tsrc_rdy_n,
    output logic [$clog2(N_REQ)-1:0]   grant_idx,
    output logic                       arb_timeout
);

    localparam int PTR_W = $clog2(N_REQ);
    localparam int CNT_W = 4;

    arb_state_t         state_reg, state_next;
    logic [PTR_W-1:0]   ptr_reg, ptr_next, ptr_adv;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [N_REQ-1:0]   my_turn_reg, my_turn_next;
    logic               drive_sel;
    logic               win_done;
    logic               bus_active;
    logic               wd_hit;

    // Only the requester under the pointer can influence the FSM
    assign drive_sel = driving_interface[ptr_reg];
    assign win_done  = (cnt_reg == CNT_W'(GRANT_WIN - 1));
    assign ptr_adv   = (ptr_reg == PTR_W'(N_REQ - 1)) ? '0 : ptr_reg + PTR_W'(1);

`ifdef TX_ARB_WATCHDOG_EN
    localparam int WD_W = $clog2(WD_LIMIT + 1);

    logic [WD_W-1:0] busy_reg, busy_next;
    logic            timeout_reg, timeout_next;

    // Last BUSY cycle permitted before the bus is reclaimed
    assign wd_hit = (busy_reg == WD_W'(WD_LIMIT - 1));

    // Watchdog counter and sticky timeout flag
    always_ff @(posedge trn_clk) begin
        if (!reset_n) begin
            busy_reg    <= '0;
            timeout_reg <= 1'b0;
        end else begin
            busy_reg    <= busy_next;
            timeout_reg <= timeout_next;
        end
    end

    // Count consecutive BUSY cycles; restart whenever BUSY is left
    always_comb begin
        busy_next    = '0;
        timeout_next = timeout_reg;
        if (state_reg == ST_BUSY && drive_sel) begin
            if (wd_hit) begin
                timeout_next = 1'b1;
            end else begin
                busy_next = busy_reg + WD_W'(1);
            end
        end
    end

    assign arb_timeout = timeout_reg;
`else
    assign wd_hit      = 1'b0;
    assign arb_timeout = 1'b0;
`endif

    // State register plus the registered pointer, window counter and offer
    always_ff @(posedge trn_clk) begin
        if (!reset_n) begin
            state_reg   <= ST_IDLE;
            ptr_reg     <= '0;
            cnt_reg     <= '0;
            my_turn_reg <= '0;
        end else begin
            state_reg   <= state_next;
            ptr_reg     <= ptr_next;
            cnt_reg     <= cnt_next;
            my_turn_reg <= my_turn_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  state_next = ST_OFFER;
            ST_OFFER: begin
                if (drive_sel)     state_next = ST_BUSY;
                else if (win_done) state_next = ST_GUARD;
            end
            ST_GUARD: state_next = drive_sel ? ST_BUSY : ST_IDLE;
            ST_BUSY: begin
                if (!drive_sel || wd_hit) state_next = ST_IDLE;
            end
            default:  state_next = ST_IDLE;
        endcase
    end

    // Output/datapath logic: offer vector, window count, pointer advance
    always_comb begin
        my_turn_next = my_turn_reg;
        cnt_next     = cnt_reg;
        ptr_next     = ptr_reg;
        bus_active   = 1'b1;
        case (state_reg)
            ST_IDLE: begin
                bus_active   = 1'b0;
                my_turn_next = {{(N_REQ-1){1'b0}}, 1'b1} << ptr_reg;
                cnt_next     = '0;
            end
            ST_OFFER: begin
                if (drive_sel || win_done) begin
                    my_turn_next = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            ST_GUARD: begin
                if (!drive_sel) ptr_next = ptr_adv;
            end
            ST_BUSY: begin
                if (!drive_sel || wd_hit) ptr_next = ptr_adv;
            end
            default: begin
                bus_active   = 1'b0;
                my_turn_next = '0;
            end
        endcase
    end

    assign my_turn   = my_turn_reg;
    assign grant_idx = ptr_reg;

    tx_trn_mux #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_mux (
        .sel                (ptr_reg),
        .active             (bus_active),
        .req_trn_td         (req_trn_td),
        .req_trn_trem_n     (req_trn_trem_n),
        .req_trn_tsof_n     (req_trn_tsof_n),
        .req_trn_teof_n     (req_trn_teof_n),
        .req_trn_tsrc_rdy_n (req_trn_tsrc_rdy_n),
        .trn_td             (trn_td),
        .trn_trem_n         (trn_trem_n),
        .trn_tsof_n         (trn_tsof_n),
        .trn_teof_n         (trn_teof_n),
        .trn_tsrc_rdy_n     (trn_tsrc_rdy_n)
    );

endmodule

// File: tb/tb_tx_trn_arbiter.sv
// Directed scoreboard bench for tx_trn_arbiter (N_REQ=3, GRANT_WIN=4,
// WD_LIMIT=16). The stimulus process queues the hand-derived expectation
// for each cycle; a monitor on the falling edge pops and compares.
module tb_tx_trn_arbiter;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic [2:0]         driving_interface = 3'b000;
    logic [2:0]         my_turn;
    logic [63:0]        trn_td;
    logic [7:0]         trn_trem_n;
    logic               trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n;
    logic [1:0]         grant_idx;
    logic               arb_timeout;

    // Per-requester source data
    logic [63:0]        td_val [3];
    logic [7:0]         trem_c [3];
    logic [2:0]         sof_c = 3'b010;
    logic [2:0]         eof_c = 3'b101;

    localparam logic [63:0] TD2 = 64'hC2C2_0000_0000_0002;

`ifdef TX_ARB_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    always #5 clk = ~clk;

    tx_trn_arbiter #(
        .N_REQ     (3),
        .GRANT_WIN (4),
        .WD_LIMIT  (16)
    ) dut (
        .trn_clk            (clk),
        .reset_n            (reset_n),
        .my_turn            (my_turn),
        .driving_interface  (driving_interface),
        .req_trn_td         ({td_val[2], td_val[1], td_val[0]}),
        .req_trn_trem_n     ({trem_c[2], trem_c[1], trem_c[0]}),
        .req_trn_tsof_n     (sof_c),
        .req_trn_teof_n     (eof_c),
        .req_trn_tsrc_rdy_n (~driving_interface),
        .trn_td             (trn_td),
        .trn_trem_n         (trn_trem_n),
        .trn_tsof_n         (trn_tsof_n),
        .trn_teof_n         (trn_teof_n),
        .trn_tsrc_rdy_n     (trn_tsrc_rdy_n),
        .grant_idx          (grant_idx),
        .arb_timeout        (arb_timeout)
    );

    typedef struct packed {
        logic [31:0] step;
        logic [2:0]  turn;
        logic [1:0]  idx;
        logic        to;
        logic [74:0] bus;
    } exp_t;

    exp_t exp_q [$];
    int   total = 0;
    int   bad   = 0;
    int   step  = 0;

    // Queue the expectation for the cycle that starts at this rising edge
    task automatic tick(input logic rst, input logic [2:0] drv, input logic [63:0] td2,
                        input logic [2:0] turn, input int idx, input int src, input logic to);
        exp_t e;
        @(posedge clk);
        #1;
        reset_n           = rst;
        driving_interface = drv;
        td_val[2]         = td2;
        e.step = step;
        e.turn = turn;
        e.idx  = idx[1:0];
        e.to   = to;
        if (src < 0)
            e.bus = {64'h0, 8'hFF, 1'b1, 1'b1, 1'b1};
        else
            e.bus = {td_val[src], trem_c[src], sof_c[src], eof_c[src], ~drv[src]};
        exp_q.push_back(e);
        step++;
    endtask

    // Monitor: compare DUT outputs with every queued expectation
    always @(negedge clk) begin
        exp_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (my_turn !== e.turn) begin
                bad++;
                $display("FAIL my_turn step=%0d got=%b want=%b", e.step, my_turn, e.turn);
            end
            total++;
            if (grant_idx !== e.idx) begin
                bad++;
                $display("FAIL grant_idx step=%0d got=%0d want=%0d", e.step, grant_idx, e.idx);
            end
            total++;
            if (arb_timeout !== e.to) begin
                bad++;
                $display("FAIL arb_timeout step=%0d got=%b want=%b", e.step, arb_timeout, e.to);
            end
            total++;
            if ({trn_td, trn_trem_n, trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n} !== e.bus) begin
                bad++;
                $display("FAIL bus step=%0d got=%h want=%h", e.step,
                         {trn_td, trn_trem_n, trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n}, e.bus);
            end
            $display("step %0d: my_turn=%b idx=%0d to=%b td=%h rdy_n=%b",
                     e.step, my_turn, grant_idx, arb_timeout, trn_td, trn_tsrc_rdy_n);
        end
    end

    initial begin
        int p;
        td_val[0] = 64'hA0A0_0000_0000_0000;
        td_val[1] = 64'hB1B1_0000_0000_0001;
        td_val[2] = TD2;
        trem_c[0] = 8'h0F;
        trem_c[1] = 8'h00;
        trem_c[2] = 8'hF0;

        // Reset state
        tick(1'b0, 3'b000, TD2, 3'b000, 0, -1, 1'b0);
        tick(1'b0, 3'b000, TD2, 3'b000, 0, -1, 1'b0);

        // Release; first offer to requester 0, which drives for 3 cycles
        tick(1'b1, 3'b000, TD2, 3'b000, 0, -1, 1'b0);
        tick(1'b1, 3'b000, TD2, 3'b001, 0,  0, 1'b0);
        tick(1'b1, 3'b001, TD2, 3'b001, 0,  0, 1'b0);
        tick(1'b1, 3'b001, TD2, 3'b000, 0,  0, 1'b0);
        tick(1'b1, 3'b001, TD2, 3'b000, 0,  0, 1'b0);
        tick(1'b1, 3'b000, TD2, 3'b000, 0,  0, 1'b0);
        tick(1'b1, 3'b000, TD2, 3'b000, 1, -1, 1'b0);

        // Silent rotation 1,2,0: 4 offer cycles, guard, idle -> period 6
        for (int rep = 0; rep < 3; rep++) begin
            p = (1 + rep) % 3;
            for (int c = 0; c < 4; c++)
                tick(1'b1, 3'b000, TD2, 3'(1 << p), p, p, 1'b0);
            tick(1'b1, 3'b000, TD2, 3'b000, p, p, 1'b0);
            tick(1'b1, 3'b000, TD2, 3'b000, (p + 1) % 3, -1, 1'b0);
        end

        // Requester 1 offered; others drive but are ignored; 1 claims in guard
        tick(1'b1, 3'b000, TD2, 3'b010, 1, 1, 1'b0);
        tick(1'b1, 3'b101, TD2, 3'b010, 1, 1, 1'b0);
        tick(1'b1, 3'b000, TD2, 3'b010, 1, 1, 1'b0);
        tick(1'b1, 3'b000, TD2, 3'b010, 1, 1, 1'b0);
        tick(1'b1, 3'b010, TD2, 3'b000, 1, 1, 1'b0);
        tick(1'b1, 3'b010, TD2, 3'b000, 1, 1, 1'b0);
        tick(1'b1, 3'b000, TD2, 3'b000, 1, 1, 1'b0);
        tick(1'b1, 3'b000, TD2, 3'b000, 2, -1, 1'b0);

        // Requester 2 holds the bus while its data changes every cycle
        tick(1'b1, 3'b100, TD2, 3'b100, 2, 2, 1'b0);
        tick(1'b1, 3'b100, 64'h1111_2222_3333_4444, 3'b000, 2, 2, 1'b0);
        tick(1'b1, 3'b100, 64'h5555_6666_7777_8888, 3'b000, 2, 2, 1'b0);
        tick(1'b1, 3'b100, 64'hFFFF_0000_FFFF_0000, 3'b000, 2, 2, 1'b0);
        tick(1'b1, 3'b100, 64'h0123_4567_89AB_CDEF, 3'b000, 2, 2, 1'b0);

        // Reset mid-BUSY: still BUSY this cycle, idle with ptr 0 next cycle
        tick(1'b0, 3'b100, TD2, 3'b000, 2, 2, 1'b0);
        tick(1'b1, 3'b000, TD2, 3'b000, 0, -1, 1'b0);

        // Requester 0 claims and holds for 20 cycles
        tick(1'b1, 3'b001, TD2, 3'b001, 0, 0, 1'b0);
        for (int k = 1; k <= 19; k++) begin
            if (WD && k == 17)
                tick(1'b1, 3'b001, TD2, 3'b000, 1, -1, 1'b1);
            else if (WD && k > 17)
                tick(1'b1, 3'b001, TD2, 3'b010, 1, 1, 1'b1);
            else
                tick(1'b1, 3'b001, TD2, 3'b000, 0, 0, 1'b0);
        end

        // Timeout stays set until reset, then everything returns to idle
        if (WD)
            tick(1'b0, 3'b000, TD2, 3'b010, 1, 1, 1'b1);
        else
            tick(1'b0, 3'b000, TD2, 3'b000, 0, 0, 1'b0);
        tick(1'b1, 3'b000, TD2, 3'b000, 0, -1, 1'b0);

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
